// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit hex display driver: scan prescaler, PWM brightness, leading-zero
// blanking, and a double-buffered load port that only swaps the shown value at frame boundaries.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 2**17,
  parameter int BRIGHT_BITS    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    notReset,
  input  logic [4*NUM_DIGITS-1:0] loadData,
  input  logic [NUM_DIGITS-1:0]   loadDp,
  input  logic                    loadValid,
  output logic                    loadReady,
  input  logic                    blankLeadingZeros,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic                    frameStart,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_full_q, pend_full_d;
  logic [7:0]              segment_q, segment_d;
  logic [NUM_DIGITS-1:0]   digit_q, digit_d;
  logic                    frame_start_q, frame_start_d;

  logic                    slot_wrap;
  logic                    boundary;
  logic                    accept;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [BRIGHT_BITS-1:0]  phase;
  logic                    lit;
  logic [7:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   dig_raw;

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  assign slot_wrap = (cnt_q == CNT_MAX);
  assign boundary  = slot_wrap && (idx_q == IDX_MAX);
  assign loadReady = !pend_full_q;
  assign accept    = loadValid && !pend_full_q;

  always_comb begin
    cnt_d = slot_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Active buffer only moves at the frame boundary; an empty pending slot lets a load bypass straight in.
  always_comb begin
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (boundary) begin
      if (pend_full_q) begin
        act_data_d  = pend_data_q;
        act_dp_d    = pend_dp_q;
        pend_full_d = 1'b0;
      end else if (accept) begin
        act_data_d = loadData;
        act_dp_d   = loadDp;
      end
    end else if (accept) begin
      pend_data_d = loadData;
      pend_dp_d   = loadDp;
      pend_full_d = 1'b1;
    end
  end

  // A digit is blanked only while every digit above it is blanked as well.
  always_comb begin
    logic higher_blank;
    blank_vec    = '0;
    higher_blank = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      blank_vec[i] = higher_blank && blankLeadingZeros &&
                     (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
      higher_blank = blank_vec[i];
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = act_data_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = blank_vec[i];
      end
    end
  end

  assign phase = cnt_q[CNT_W-1 -: BRIGHT_BITS];
  assign lit   = (phase < brightness) && !cur_blank;

  always_comb begin
    seg_raw = lit ? {cur_dp, hex_font(cur_nib)} : 8'h00;
    dig_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_raw[i] = lit && (idx_q == IDX_W'(i));
    end
    segment_d     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    digit_d       = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
    frame_start_d = boundary;
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_full_q   <= 1'b0;
      segment_q     <= {8{SEG_ACTIVE_LOW}};
      digit_q       <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_full_q   <= pend_full_d;
      segment_q     <= segment_d;
      digit_q       <= digit_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segment    = segment_q;
  assign digit      = digit_q;
  assign frameStart = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (4 digits, 16-cycle slots, 2-bit brightness, active-low pins):
// table-driven frame vectors, hand sequences for handshake/bypass/reset, and a per-cycle reference model.
module tb_seven_seg_scan_driver;
  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BB = 2;
  localparam int FRAME = ND * SD;

  logic        clock = 1'b0;
  logic        notReset = 1'b1;
  logic [15:0] loadData = '0;
  logic [3:0]  loadDp = '0;
  logic        loadValid = 1'b0;
  logic        loadReady;
  logic        blankLeadingZeros = 1'b0;
  logic [1:0]  brightness = '0;
  logic        frameStart;
  logic [7:0]  segment;
  logic [3:0]  digit;

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_BITS(BB),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .notReset(notReset), .loadData(loadData), .loadDp(loadDp),
    .loadValid(loadValid), .loadReady(loadReady), .blankLeadingZeros(blankLeadingZeros),
    .brightness(brightness), .frameStart(frameStart), .segment(segment), .digit(digit)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: time since reset plus the two buffers; expected outputs lag by one cycle.
  int          m_cyc;
  logic [15:0] m_act, m_pdata;
  logic [3:0]  m_actdp, m_pdp;
  bit          m_pfull;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  bit          e_fs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int top_digit(input logic [15:0] d, input logic [3:0] dp);
    int t = 0;
    for (int i = 0; i < ND; i++)
      if (d[4*i +: 4] != 4'h0 || dp[i]) t = i;
    return t;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_act = '0; m_actdp = '0; m_pfull = 0; m_pdata = '0; m_pdp = '0;
    e_seg = 8'hFF; e_dig = 4'hF; e_fs = 0;
  endtask

  task automatic model_step();
    int cnt, slot, phase;
    bit bnd, blanked, lit, acc;
    cnt     = m_cyc % SD;
    slot    = (m_cyc / SD) % ND;
    bnd     = (m_cyc % FRAME) == FRAME - 1;
    phase   = cnt * (1 << BB) / SD;
    blanked = blankLeadingZeros && (slot > top_digit(m_act, m_actdp));
    lit     = (phase < int'(brightness)) && !blanked;
    e_seg   = lit ? ~{m_actdp[slot], FONT[m_act[4*slot +: 4]]} : 8'hFF;
    e_dig   = lit ? ~(4'b0001 << slot) : 4'hF;
    e_fs    = bnd;
    acc     = loadValid && !m_pfull;
    if (bnd) begin
      if (m_pfull) begin
        m_act = m_pdata; m_actdp = m_pdp; m_pfull = 0;
      end else if (acc) begin
        m_act = loadData; m_actdp = loadDp;
      end
    end else if (acc) begin
      m_pfull = 1; m_pdata = loadData; m_pdp = loadDp;
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clock);
    if (notReset) model_step();
    else model_reset();
    #1;
    check("model_segment", segment, e_seg);
    check("model_digit", digit, e_dig);
    check("model_frameStart", frameStart, e_fs);
    check("model_loadReady", loadReady, !m_pfull);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 2 * FRAME && (m_cyc % FRAME) != pos; i++) tick();
  endtask

  task automatic wait_frame();
    bit got = 0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      tick();
      got = frameStart;
    end
    check("frame_timeout", got, 1);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    bit rdy = loadReady;
    for (int i = 0; i < 3 * FRAME && !rdy; i++) begin
      tick();
      rdy = loadReady;
    end
    check("load_ready_timeout", rdy, 1);
    loadValid = 1'b1; loadData = d; loadDp = dp;
    tick();
    loadValid = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            bl;
    logic [1:0]      br;
    logic [3:0][7:0] seg;
    logic [3:0][4:0] on;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, 2'd3, {8'hF9, 8'hA4, 8'h88, 8'h8E}, {5'd12, 5'd12, 5'd12, 5'd12}};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 2'd3, {8'hFF, 8'hFF, 8'h92, 8'hC0}, {5'd0, 5'd0, 5'd12, 5'd12}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 2'd2, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {5'd0, 5'd0, 5'd0, 5'd8}};
    vecs[3] = '{16'h0005, 4'b0100, 1'b1, 2'd1, {8'hFF, 8'h40, 8'hC0, 8'h92}, {5'd0, 5'd4, 5'd4, 5'd4}};
    vecs[4] = '{16'h8888, 4'b0000, 1'b0, 2'd0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {5'd0, 5'd0, 5'd0, 5'd0}};
    vecs[5] = '{16'h0000, 4'b0000, 1'b0, 2'd3, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, {5'd12, 5'd12, 5'd12, 5'd12}};
    vecs[6] = '{16'h3BCD, 4'b1001, 1'b1, 2'd2, {8'h30, 8'h83, 8'hC6, 8'h21}, {5'd8, 5'd8, 5'd8, 5'd8}};
    vecs[7] = '{16'hE976, 4'b0000, 1'b0, 2'd3, {8'h86, 8'h90, 8'hF8, 8'h82}, {5'd12, 5'd12, 5'd12, 5'd12}};

    // Reset state
    #1 notReset = 1'b0;
    #1;
    check("rst_segment", segment, 8'hFF);
    check("rst_digit", digit, 4'hF);
    check("rst_loadReady", loadReady, 1'b1);
    check("rst_frameStart", frameStart, 1'b0);
    model_reset();
    repeat (3) tick();
    notReset = 1'b1;
    n = 0;
    for (int i = 0; i < 3 * FRAME && !frameStart; i++) begin
      tick();
      n++;
    end
    check("first_frame_period", n, FRAME);
    n = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      n++;
      if (frameStart) break;
    end
    check("frame_period", n, FRAME);

    // Table-driven whole-frame vectors
    foreach (vecs[v]) begin
      int on_cnt [4];
      int bad_seg, multi;
      brightness = vecs[v].br;
      blankLeadingZeros = vecs[v].bl;
      load(vecs[v].data, vecs[v].dp);
      wait_frame();
      on_cnt = '{0, 0, 0, 0};
      bad_seg = 0; multi = 0;
      for (int k = 0; k < FRAME; k++) begin
        int s;
        tick();
        s = k / SD;
        for (int j = 0; j < ND; j++) begin
          if (!digit[j]) begin
            if (j != s) multi++;
            else begin
              on_cnt[s]++;
              if (segment !== vecs[v].seg[s]) bad_seg++;
            end
          end
        end
      end
      for (int s = 0; s < ND; s++)
        check($sformatf("vec%0d_on_digit%0d", v, s), on_cnt[s], int'(vecs[v].on[s]));
      check($sformatf("vec%0d_segments", v), bad_seg, 0);
      check($sformatf("vec%0d_wrong_digit", v), multi, 0);
    end

    // Handshake: mid-frame load blocks a second request until the boundary
    brightness = 2'd3; blankLeadingZeros = 1'b0;
    run_to(20);
    loadValid = 1'b1; loadData = 16'h1234; loadDp = 4'h0;
    tick();
    check("hs_ready_low", loadReady, 1'b0);
    loadData = 16'h5678;
    run_to(50);
    tick();
    check("hs_old_still_shown", segment, 8'h86);
    run_to(60);
    loadValid = 1'b0;
    wait_frame();
    check("hs_ready_back", loadReady, 1'b1);
    tick();
    check("hs_new_digit0_seg", segment, 8'h99);
    check("hs_new_digit0_pin", digit, 4'hE);
    wait_frame();
    tick();
    check("hs_second_ignored", segment, 8'h99);

    // Bypass: load presented exactly on the boundary cycle
    run_to(FRAME - 1);
    loadValid = 1'b1; loadData = 16'h000C; loadDp = 4'h0;
    tick();
    loadValid = 1'b0;
    check("byp_ready", loadReady, 1'b1);
    check("byp_frameStart", frameStart, 1'b1);
    tick();
    check("byp_seg", segment, 8'hC6);
    check("byp_pin", digit, 4'hE);

    // Async reset mid-slot with a pending load
    run_to(30);
    loadValid = 1'b1; loadData = 16'hAAAA;
    tick();
    loadValid = 1'b0;
    check("ar_pending", loadReady, 1'b0);
    #2 notReset = 1'b0;
    #1;
    check("ar_segment", segment, 8'hFF);
    check("ar_digit", digit, 4'hF);
    check("ar_loadReady", loadReady, 1'b1);
    check("ar_frameStart", frameStart, 1'b0);
    model_reset();
    repeat (2) tick();
    notReset = 1'b1;
    wait_frame();
    tick();
    check("ar_discarded", segment, 8'hC0);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      loadValid = ($urandom_range(0, 15) == 0);
      loadData  = 16'($urandom);
      loadDp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 99) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 99) == 0) blankLeadingZeros = 1'($urandom);
      if ($urandom_range(0, 7) == 0) loadData = 16'($urandom_range(0, 255));
      tick();
    end
    loadValid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
